// File: rtl/cmd_frame_parser.sv
// Host control frame parser: hunts 55 AA sync, buffers payload, verifies checksum, replays as register writes.
// Latency: frame_ok and the first register write appear the cycle after the checksum byte; one write per cycle.
// Backpressure: none; input is strobe-only, and bytes arriving during replay are discarded and flagged on drop.
module cmd_frame_parser #(
    parameter int MAXLEN = 16,
    parameter int TOW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_dat,
    input  logic        in_vd,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_dat,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        drop,
    output logic [15:0] err_cnt,
    output logic        busy
);

    // Buffer index width; a one-entry buffer still needs a one-bit index.
    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);
    // The idle counter fires when it is about to reach (2^TOW)-1.
    localparam logic [TOW-1:0] IDLE_LAST = {{(TOW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_HUNT0,
        S_HUNT1,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_REPLAY
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [7:0]     r_base;
    logic [7:0]     r_len;
    logic [7:0]     r_idx;
    logic [7:0]     r_sum;
    logic [TOW-1:0] r_idle;
    logic [7:0]     r_buf [0:MAXLEN-1];

    logic           r_we;
    logic [7:0]     r_addr;
    logic [7:0]     r_dat;
    logic           r_ok;
    logic           r_err;
    logic           r_drop;
    logic [15:0]    r_err_cnt;

    logic           w_ok_nxt;
    logic           w_err_nxt;
    logic           w_active;
    logic           w_timeout;
    logic           w_len_bad;
    logic [7:0]     w_sum_in;
    logic           w_csum_good;
    logic           w_pay_last;
    logic           w_rep_done;
    logic           w_start_rep;
    logic           w_rep_step;
    logic [IW-1:0]  w_idx_lo;

    // Per-byte decode terms shared by the FSM and the datapath.
    assign w_active    = (r_state == S_ADDR) || (r_state == S_LEN) ||
                         (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    assign w_timeout   = w_active && !in_vd && (r_idle == IDLE_LAST);
    assign w_len_bad   = (in_dat == 8'd0) || (in_dat > MAXLEN_B);
    assign w_sum_in    = r_sum + in_dat;
    assign w_csum_good = (w_sum_in == 8'd0);
    assign w_pay_last  = (r_idx == (r_len - 8'd1));
    assign w_rep_done  = (r_idx == r_len);
    assign w_idx_lo    = r_idx[IW-1:0];
    assign w_start_rep = (r_state == S_CSUM) && in_vd && w_csum_good;
    assign w_rep_step  = (r_state == S_REPLAY) && !w_rep_done;

    // State register; reset aborts any frame or replay in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and frame verdict decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_HUNT0: begin
                if (in_vd && (in_dat == 8'h55)) begin
                    w_state_nxt = S_HUNT1;
                end
            end
            S_HUNT1: begin
                if (in_vd) begin
                    if (in_dat == 8'hAA) begin
                        w_state_nxt = S_ADDR;
                    end else if (in_dat == 8'h55) begin
                        w_state_nxt = S_HUNT1;
                    end else begin
                        w_state_nxt = S_HUNT0;
                    end
                end
            end
            S_ADDR: begin
                if (in_vd) begin
                    w_state_nxt = S_LEN;
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT0;
                    w_err_nxt   = 1'b1;
                end
            end
            S_LEN: begin
                if (in_vd) begin
                    if (w_len_bad) begin
                        w_state_nxt = S_HUNT0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT0;
                    w_err_nxt   = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (in_vd) begin
                    if (w_pay_last) begin
                        w_state_nxt = S_CSUM;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT0;
                    w_err_nxt   = 1'b1;
                end
            end
            S_CSUM: begin
                if (in_vd) begin
                    if (w_csum_good) begin
                        w_state_nxt = S_REPLAY;
                        w_ok_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_HUNT0;
                        w_err_nxt   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT0;
                    w_err_nxt   = 1'b1;
                end
            end
            S_REPLAY: begin
                if (w_rep_done) begin
                    w_state_nxt = S_HUNT0;
                end
            end
            default: begin
                w_state_nxt = S_HUNT0;
            end
        endcase
    end

    // Inter-byte idle counter: runs only while inside a frame body, cleared by any byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_active && !in_vd && !w_timeout) begin
            r_idle <= r_idle + 1'b1;
        end else begin
            r_idle <= '0;
        end
    end

    // Frame header capture and running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_sum  <= '0;
        end else if (in_vd) begin
            if (r_state == S_ADDR) begin
                r_base <= in_dat;
                r_sum  <= in_dat;
            end else if (r_state == S_LEN) begin
                r_sum <= w_sum_in;
                if (!w_len_bad) begin
                    r_len <= in_dat;
                end
            end else if (r_state == S_PAYLOAD) begin
                r_sum <= w_sum_in;
            end
        end
    end

    // Shared index: payload write pointer while filling, replay read pointer while writing out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if ((r_state == S_LEN) && in_vd) begin
            r_idx <= '0;
        end else if ((r_state == S_PAYLOAD) && in_vd) begin
            r_idx <= r_idx + 8'd1;
        end else if (w_start_rep) begin
            r_idx <= 8'd1;
        end else if (w_rep_step) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    // Payload buffer: written only while filling, read only while replaying.
    always_ff @(posedge clk) begin
        if ((r_state == S_PAYLOAD) && in_vd) begin
            r_buf[w_idx_lo] <= in_dat;
        end
    end

    // Register write port; element 0 goes out with frame_ok, the rest follow one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_dat  <= '0;
        end else if (w_start_rep) begin
            r_we   <= 1'b1;
            r_addr <= r_base;
            r_dat  <= r_buf[0];
        end else if (w_rep_step) begin
            r_we   <= 1'b1;
            r_addr <= r_base + r_idx;
            r_dat  <= r_buf[w_idx_lo];
        end else begin
            r_we   <= 1'b0;
        end
    end

    // Status pulses and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_drop    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ok   <= w_ok_nxt;
            r_err  <= w_err_nxt;
            r_drop <= (r_state == S_REPLAY) && in_vd;
            if (w_err_nxt && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign reg_we    = r_we;
    assign reg_addr  = r_addr;
    assign reg_dat   = r_dat;
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    assign drop      = r_drop;
    assign err_cnt   = r_err_cnt;
    assign busy      = (r_state != S_HUNT0);

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: directed scenarios plus randomized frames against a frame-level model.
// Latency: expected events are pinned to the clock edge that samples each frame's checksum byte.
// Backpressure: none; stimulus is a pure valid strobe, with extra bytes injected during replay.
module tb_cmd_frame_parser;

    localparam int MAXLEN = 16;
    localparam int TOW    = 10;
    localparam int TO_CYC = (1 << TOW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_dat = 8'h00;
    logic        in_vd = 1'b0;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_dat;
    logic        frame_ok;
    logic        frame_err;
    logic        drop;
    logic [15:0] err_cnt;
    logic        busy;

    always #5 clk = ~clk;

    cmd_frame_parser #(.MAXLEN(MAXLEN), .TOW(TOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_dat    (in_dat),
        .in_vd     (in_vd),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_dat   (reg_dat),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .drop      (drop),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         exp_err_cnt = 0;
    wr_t        wr_q[$];
    wr_t        exp_q[$];
    int         ok_q[$];
    int         err_q[$];
    int         drop_q[$];
    bit         busy_hist[int];
    logic [7:0] tx_q[$];
    logic [7:0] pl[$];

    // Monitor: records every output event with the index of the edge that produced it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (reg_we === 1'b1) wr_q.push_back('{c: cyc, a: reg_addr, d: reg_dat});
        if (frame_ok === 1'b1) ok_q.push_back(cyc);
        if (frame_err === 1'b1) err_q.push_back(cyc);
        if (drop === 1'b1) drop_q.push_back(cyc);
        busy_hist[cyc] = (busy === 1'b1);
    end

    // Drive one cycle of input; e is the edge index that samples it.
    task automatic drive(input logic v, input logic [7:0] d, output int e);
        @(negedge clk);
        in_vd  = v;
        in_dat = d;
        e      = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), e);
    endtask

    task automatic clear_mon();
        wr_q.delete();
        exp_q.delete();
        ok_q.delete();
        err_q.delete();
        drop_q.delete();
    endtask

    // Reference frame builder: checksum is the two's complement of ADDR+LEN+payload.
    task automatic build_frame(input logic [7:0] addr, input logic bad);
        logic [7:0] s;
        logic [7:0] cs;
        s = addr + 8'(pl.size());
        foreach (pl[i]) s = s + pl[i];
        cs = 8'd0 - s;
        if (bad) cs = cs + 8'($urandom_range(1, 255));
        tx_q.delete();
        tx_q.push_back(8'h55);
        tx_q.push_back(8'hAA);
        tx_q.push_back(addr);
        tx_q.push_back(8'(pl.size()));
        foreach (pl[i]) tx_q.push_back(pl[i]);
        tx_q.push_back(cs);
    endtask

    task automatic send_tx(input int gap_max, output int last_e);
        last_e = 0;
        foreach (tx_q[i]) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            drive(1'b1, tx_q[i], last_e);
        end
    endtask

    // Accepted frame n: write i lands on edge n+i at address base+i (mod 256).
    task automatic expect_writes(input logic [7:0] addr, input int n);
        foreach (pl[i]) exp_q.push_back('{c: n + i, a: addr + 8'(i), d: pl[i]});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
        checks++; if (reg_dat !== 8'h00) begin failures++; $display("FAIL reset_reg_dat got=%h exp=00", reg_dat); end
        checks++; if (frame_ok !== 1'b0) begin failures++; $display("FAIL reset_frame_ok got=%b exp=0", frame_ok); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_valid_frame();
        int n;
        clear_mon();
        pl = '{8'h01, 8'h02};
        build_frame(8'h10, 1'b0);
        send_tx(0, n);
        idle(6);
        exp_q.push_back('{c: n, a: 8'h10, d: 8'h01});
        exp_q.push_back('{c: n + 1, a: 8'h11, d: 8'h02});
        checks++; if (ok_q.size() != 1 || ok_q[0] != n) begin failures++; $display("FAIL valid_ok got_n=%0d exp_edge=%0d", ok_q.size(), n); end
        checks++; if (err_q.size() != 0) begin failures++; $display("FAIL valid_no_err got=%0d exp=0", err_q.size()); end
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL valid_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL valid_wr%0d exp edge=%0d a=%h d=%h", i, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++; if (busy_hist[n + 1] !== 1'b1 || busy_hist[n + 2] !== 1'b0) begin failures++; $display("FAIL valid_busy_drop got=%b%b exp=10", busy_hist[n + 1], busy_hist[n + 2]); end
    endtask

    task automatic test_bad_csum();
        int n;
        clear_mon();
        pl = '{8'h01, 8'h02};
        build_frame(8'h10, 1'b0);
        tx_q[tx_q.size() - 1] = 8'hEE;
        send_tx(0, n);
        idle(6);
        exp_err_cnt++;
        checks++; if (err_q.size() != 1 || err_q[0] != n) begin failures++; $display("FAIL badcs_err got_n=%0d exp_edge=%0d", err_q.size(), n); end
        checks++; if (wr_q.size() != 0 || ok_q.size() != 0) begin failures++; $display("FAIL badcs_no_write got=%0d/%0d exp=0/0", wr_q.size(), ok_q.size()); end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin failures++; $display("FAIL badcs_err_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt); end
        checks++; if (busy_hist[n] !== 1'b0) begin failures++; $display("FAIL badcs_busy got=%b exp=0", busy_hist[n]); end
    endtask

    task automatic test_addr_wrap();
        int n;
        clear_mon();
        pl = '{8'hAA, 8'hBB};
        build_frame(8'hFF, 1'b0);
        send_tx(0, n);
        idle(6);
        exp_q.push_back('{c: n, a: 8'hFF, d: 8'hAA});
        exp_q.push_back('{c: n + 1, a: 8'h00, d: 8'hBB});
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL wrap_wr%0d exp edge=%0d a=%h d=%h", i, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_resync();
        int n;
        clear_mon();
        pl = '{8'h07};
        build_frame(8'h20, 1'b0);
        tx_q.push_front(8'h55);
        tx_q.push_front(8'h13);
        tx_q.push_front(8'h55);
        send_tx(0, n);
        idle(5);
        checks++; if (ok_q.size() != 1 || err_q.size() != 0) begin failures++; $display("FAIL resync_verdict got ok=%0d err=%0d exp ok=1 err=0", ok_q.size(), err_q.size()); end
        checks++;
        if (wr_q.size() != 1 || wr_q[0].c != n || wr_q[0].a !== 8'h20 || wr_q[0].d !== 8'h07) begin
            failures++;
            $display("FAIL resync_write got_n=%0d exp one write edge=%0d a=20 d=07", wr_q.size(), n);
        end
    endtask

    task automatic test_len_errors();
        int n;
        int lens[2];
        lens[0] = 0;
        lens[1] = MAXLEN + 1;
        foreach (lens[k]) begin
            clear_mon();
            tx_q = '{8'h55, 8'hAA, 8'h10, 8'(lens[k])};
            send_tx(0, n);
            idle(4);
            exp_err_cnt++;
            checks++; if (err_q.size() != 1 || err_q[0] != n) begin failures++; $display("FAIL len%0d_err got_n=%0d exp_edge=%0d", lens[k], err_q.size(), n); end
            checks++; if (busy_hist[n] !== 1'b0 || wr_q.size() != 0) begin failures++; $display("FAIL len%0d_idle got busy=%b writes=%0d exp 0/0", lens[k], busy_hist[n], wr_q.size()); end
        end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin failures++; $display("FAIL len_err_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        int e;
        clear_mon();
        tx_q = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h01};
        send_tx(0, n);
        for (int i = 0; i < TO_CYC + 80 && err_q.size() == 0; i++) idle(1);
        idle(3);
        exp_err_cnt++;
        checks++; if (err_q.size() != 1 || err_q[0] != n + TO_CYC) begin failures++; $display("FAIL timeout_err got_n=%0d first=%0d exp_edge=%0d", err_q.size(), (err_q.size() > 0) ? err_q[0] - n : -1, TO_CYC); end
        checks++; if (busy_hist[n + TO_CYC - 1] !== 1'b1 || busy_hist[n + TO_CYC] !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b%b exp=10", busy_hist[n + TO_CYC - 1], busy_hist[n + TO_CYC]); end
        // Long gaps just under the limit must not trip the timeout.
        clear_mon();
        pl = '{8'h5A};
        build_frame(8'h30, 1'b0);
        foreach (tx_q[i]) begin
            if (i >= 4) idle(TO_CYC - 23);
            drive(1'b1, tx_q[i], n);
        end
        idle(5);
        checks++; if (err_q.size() != 0 || ok_q.size() != 1) begin failures++; $display("FAIL timeout_recover got ok=%0d err=%0d exp ok=1 err=0", ok_q.size(), err_q.size()); end
        checks++; if (wr_q.size() != 1 || wr_q[0].c != n || wr_q[0].a !== 8'h30 || wr_q[0].d !== 8'h5A) begin failures++; $display("FAIL timeout_recover_wr got_n=%0d exp a=30 d=5A", wr_q.size()); end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin failures++; $display("FAIL timeout_err_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt); end
        e = n;
    endtask

    task automatic test_replay_drop();
        int n;
        int e;
        clear_mon();
        pl.delete();
        for (int i = 0; i < MAXLEN; i++) pl.push_back(8'($urandom));
        build_frame(8'hF8, 1'b0);
        send_tx(0, n);
        expect_writes(8'hF8, n);
        for (int i = 0; i < MAXLEN; i++) drive(1'b1, 8'h55, e);
        idle(4);
        checks++; if (ok_q.size() != 1 || ok_q[0] != n || err_q.size() != 0) begin failures++; $display("FAIL drop_verdict got ok=%0d err=%0d exp ok=1 err=0", ok_q.size(), err_q.size()); end
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL drop_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL drop_wr%0d exp edge=%0d a=%h d=%h", i, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++; if (drop_q.size() != MAXLEN) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", drop_q.size(), MAXLEN); end
        for (int i = 0; i < drop_q.size() && i < MAXLEN; i++) begin
            checks++; if (drop_q[i] != n + 1 + i) begin failures++; $display("FAIL drop_edge%0d got=%0d exp=%0d", i, drop_q[i], n + 1 + i); end
        end
        checks++; if (busy_hist[n + MAXLEN + 1] !== 1'b0) begin failures++; $display("FAIL drop_busy_after got=%b exp=0", busy_hist[n + MAXLEN + 1]); end
    endtask

    task automatic test_reset_replay();
        int n;
        clear_mon();
        pl.delete();
        for (int i = 0; i < MAXLEN; i++) pl.push_back(8'($urandom));
        build_frame(8'h40, 1'b0);
        send_tx(0, n);
        idle(4);
        @(posedge clk);
        #1;
        checks++; if (reg_we !== 1'b1) begin failures++; $display("FAIL rstrep_pre_we got=%b exp=1", reg_we); end
        #1;
        rst = 1'b1;
        #1;
        exp_err_cnt = 0;
        checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL rstrep_we got=%b exp=0", reg_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstrep_busy got=%b exp=0", busy); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rstrep_err_cnt got=%0d exp=0", err_cnt); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        idle(MAXLEN + 8);
        checks++; if (wr_q.size() != 0 || ok_q.size() != 0 || err_q.size() != 0) begin failures++; $display("FAIL rstrep_quiet got wr=%0d ok=%0d err=%0d exp 0", wr_q.size(), ok_q.size(), err_q.size()); end
    endtask

    task automatic test_random();
        int n;
        int e;
        int len;
        logic [7:0] addr;
        logic bad;
        logic [7:0] g;
        int exp_ok[$];
        int exp_er[$];
        clear_mon();
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, MAXLEN);
            addr = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            build_frame(addr, bad);
            send_tx(3, n);
            if (bad) begin
                exp_er.push_back(n);
                exp_err_cnt++;
            end else begin
                exp_ok.push_back(n);
                expect_writes(addr, n);
            end
            idle(len + 2 + $urandom_range(0, 3));
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                g = 8'($urandom);
                if (g == 8'h55) g = 8'h56;
                drive(1'b1, g, e);
            end
        end
        idle(MAXLEN + 4);
        checks++; if (ok_q != exp_ok) begin failures++; $display("FAIL rand_ok_edges got_n=%0d exp_n=%0d", ok_q.size(), exp_ok.size()); end
        checks++; if (err_q != exp_er) begin failures++; $display("FAIL rand_err_edges got_n=%0d exp_n=%0d", err_q.size(), exp_er.size()); end
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i].c != exp_q[i].c || wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL rand_wr%0d exp edge=%0d a=%h d=%h", i, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin failures++; $display("FAIL rand_err_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_csum();
        test_addr_wrap();
        test_resync();
        test_len_errors();
        test_timeout();
        test_replay_drop();
        test_reset_replay();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
